// File: rtl/fxp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fxp_pkg
// Purpose  : Q16.16 fixed-point constants and saturating-add helpers.
// Revision : 1.0 - initial release
// ============================================================================
package fxp_pkg;

    localparam logic [31:0] Q16_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] Q16_MIN = 32'h8000_0000;
    localparam logic [31:0] Q16_ONE = 32'h0001_0000;

    // Signed add at 33 bits, clamped back into the 32-bit Q16.16 range.
    function automatic logic [31:0] fxp_sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {a[31], a} + {b[31], b};
        if (s[32] != s[31]) begin
            return s[32] ? Q16_MIN : Q16_MAX;
        end
        return s[31:0];
    endfunction

    function automatic logic fxp_add_ovf(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {a[31], a} + {b[31], b};
        return s[32] != s[31];
    endfunction

endpackage
`default_nettype wire

// File: rtl/position_tracker.sv
`default_nettype none
// ============================================================================
// Module   : position_tracker
// Purpose  : Net-position accumulator over a fill stream, emitting one
//            {position, beta} beat per accepted fill to the risk stage.
// Revision : 1.0 - initial release
// ============================================================================
module position_tracker
    import fxp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fill_valid,
    output logic        fill_ready,
    input  logic [31:0] fill_qty,
    input  logic        fill_side,
    input  logic        beta_wr,
    input  logic [31:0] beta_cfg,
    input  logic        clear,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] position_out,
    output logic [31:0] beta_out,
    output logic        sat_flag,
    output logic [15:0] fill_count
);

    logic [31:0] r_position;
    logic [31:0] r_beta;
    logic [31:0] r_pos_out;
    logic [31:0] r_beta_out;
    logic        r_out_valid;
    logic        r_sat;
    logic [15:0] r_count;

    logic        w_fill_ready;
    logic        w_accept;
    logic [31:0] w_qty_mag;
    logic [31:0] w_addend;
    logic [31:0] w_next_pos;
    logic        w_ovf;
    logic [31:0] w_beta_eff;

    // Clear blocks acceptance so the producer retries after the clear edge.
    assign w_fill_ready = !clear && (!r_out_valid || out_ready);
    assign w_accept     = fill_valid && w_fill_ready;

    // Bit 31 of the quantity is ignored, so negation never overflows.
    assign w_qty_mag  = {1'b0, fill_qty[30:0]};
    assign w_addend   = fill_side ? w_qty_mag : (~w_qty_mag + 32'd1);
    assign w_next_pos = fxp_sat_add(r_position, w_addend);
    assign w_ovf      = fxp_add_ovf(r_position, w_addend);
    assign w_beta_eff = beta_wr ? beta_cfg : r_beta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_position <= '0;
            r_sat      <= 1'b0;
            r_count    <= '0;
        end else if (clear) begin
            r_position <= '0;
            r_sat      <= 1'b0;
            r_count    <= '0;
        end else if (w_accept) begin
            r_position <= w_next_pos;
            r_sat      <= r_sat | w_ovf;
            r_count    <= r_count + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beta <= Q16_ONE;
        end else if (beta_wr) begin
            r_beta <= beta_cfg;
        end
    end

    // Single-entry output register: loads on accept, drains on consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_pos_out   <= '0;
            r_beta_out  <= Q16_ONE;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_pos_out   <= w_next_pos;
            r_beta_out  <= w_beta_eff;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign fill_ready   = w_fill_ready;
    assign out_valid    = r_out_valid;
    assign position_out = r_pos_out;
    assign beta_out     = r_beta_out;
    assign sat_flag     = r_sat;
    assign fill_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_position_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_position_tracker
// Purpose  : Directed vector bench for position_tracker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_position_tracker;

    logic        clk;
    logic        rst_n;
    logic        fill_valid;
    logic        fill_ready;
    logic [31:0] fill_qty;
    logic        fill_side;
    logic        beta_wr;
    logic [31:0] beta_cfg;
    logic        clear;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] position_out;
    logic [31:0] beta_out;
    logic        sat_flag;
    logic [15:0] fill_count;

    int total;
    int bad;

    position_tracker u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fill_valid   (fill_valid),
        .fill_ready   (fill_ready),
        .fill_qty     (fill_qty),
        .fill_side    (fill_side),
        .beta_wr      (beta_wr),
        .beta_cfg     (beta_cfg),
        .clear        (clear),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .position_out (position_out),
        .beta_out     (beta_out),
        .sat_flag     (sat_flag),
        .fill_count   (fill_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        fv;
        logic [31:0] qty;
        logic        side;
        logic        bwr;
        logic [31:0] bcfg;
        logic        clr;
        logic        ordy;
        logic        e_rdy;
        logic        e_ov;
        logic [31:0] e_pos;
        logic [31:0] e_beta;
        logic        e_sat;
        logic [15:0] e_cnt;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s [%0d]: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        fill_valid = v.fv;
        fill_qty   = v.qty;
        fill_side  = v.side;
        beta_wr    = v.bwr;
        beta_cfg   = v.bcfg;
        clear      = v.clr;
        out_ready  = v.ordy;
    endtask

    task automatic check_outs(input int idx, input vec_t v);
        chk("out_valid",    idx, {31'd0, out_valid}, {31'd0, v.e_ov});
        chk("position_out", idx, position_out, v.e_pos);
        chk("beta_out",     idx, beta_out, v.e_beta);
        chk("sat_flag",     idx, {31'd0, sat_flag}, {31'd0, v.e_sat});
        chk("fill_count",   idx, {16'd0, fill_count}, {16'd0, v.e_cnt});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        //            fv  qty            sd   bwr  bcfg           clr  ordy rdy  ov   pos            beta           sat  cnt
        vecs[0]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0001_0000, 1'b0, 16'd0};
        vecs[1]  = '{1'b1, 32'h0002_8000, 1'b1, 1'b0, 32'h0,       1'b0, 1'b1, 1'b1, 1'b1, 32'h0002_8000, 32'h0001_0000, 1'b0, 16'd1};
        vecs[2]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 1'b0, 1'b0, 32'h0002_8000, 32'h0001_0000, 1'b0, 16'd0};
        vecs[3]  = '{1'b1, 32'h0003_0000, 1'b1, 1'b0, 32'h0,       1'b0, 1'b1, 1'b1, 1'b1, 32'h0003_0000, 32'h0001_0000, 1'b0, 16'd1};
        vecs[4]  = '{1'b1, 32'h0005_0000, 1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFE_0000, 32'h0001_0000, 1'b0, 16'd2};
        vecs[5]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFE_0000, 32'h0001_0000, 1'b0, 16'd2};
        vecs[6]  = '{1'b1, 32'h0001_0000, 1'b1, 1'b0, 32'h0,       1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFE_0000, 32'h0001_0000, 1'b0, 16'd2};
        vecs[7]  = '{1'b1, 32'h0001_0000, 1'b1, 1'b0, 32'h0,       1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_0000, 32'h0001_0000, 1'b0, 16'd3};
        vecs[8]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_0000, 32'h0001_0000, 1'b0, 16'd3};
        vecs[9]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_0000, 32'h0001_0000, 1'b0, 16'd0};
        vecs[10] = '{1'b1, 32'h7FFF_0000, 1'b1, 1'b0, 32'h0,       1'b0, 1'b1, 1'b1, 1'b1, 32'h7FFF_0000, 32'h0001_0000, 1'b0, 16'd1};
        vecs[11] = '{1'b1, 32'h0002_0000, 1'b1, 1'b0, 32'h0,       1'b0, 1'b1, 1'b1, 1'b1, 32'h7FFF_FFFF, 32'h0001_0000, 1'b1, 16'd2};
        vecs[12] = '{1'b1, 32'h0001_0000, 1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 1'b1, 1'b1, 32'h7FFE_FFFF, 32'h0001_0000, 1'b1, 16'd3};
        vecs[13] = '{1'b1, 32'h0001_0000, 1'b1, 1'b1, 32'h0000_8000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h7FFF_FFFF, 32'h0000_8000, 1'b1, 16'd4};
        vecs[14] = '{1'b1, 32'h8001_0000, 1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 1'b1, 1'b1, 32'h7FFE_FFFF, 32'h0000_8000, 1'b1, 16'd5};
        vecs[15] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0002_0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h7FFE_FFFF, 32'h0000_8000, 1'b1, 16'd5};
        vecs[16] = '{1'b1, 32'h0001_0000, 1'b1, 1'b0, 32'h0,       1'b1, 1'b0, 1'b0, 1'b1, 32'h7FFE_FFFF, 32'h0000_8000, 1'b0, 16'd0};
        vecs[17] = '{1'b1, 32'h0001_0000, 1'b1, 1'b1, 32'h0003_0000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h7FFE_FFFF, 32'h0000_8000, 1'b0, 16'd0};
        vecs[18] = '{1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h0,       1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 32'h0003_0000, 1'b0, 16'd1};
        vecs[19] = '{1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_0001, 32'h0003_0000, 1'b0, 16'd2};
        vecs[20] = '{1'b1, 32'h0001_0000, 1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_0000, 32'h0003_0000, 1'b1, 16'd3};

        rst_n      = 1'b0;
        fill_valid = 1'b0;
        fill_qty   = '0;
        fill_side  = 1'b0;
        beta_wr    = 1'b0;
        beta_cfg   = '0;
        clear      = 1'b0;
        out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", -1, {31'd0, out_valid}, 32'd0);
        chk("rst_position",  -1, position_out, 32'h0000_0000);
        chk("rst_beta",      -1, beta_out, 32'h0001_0000);
        chk("rst_sat",       -1, {31'd0, sat_flag}, 32'd0);
        chk("rst_count",     -1, {16'd0, fill_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_fill_ready", -1, {31'd0, fill_ready}, 32'd1);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk("fill_ready", i, {31'd0, fill_ready}, {31'd0, vecs[i].e_rdy});
            @(posedge clk);
            #1;
            check_outs(i, vecs[i]);
        end

        // Counter wrap over 65536 zero-quantity fills.
        @(negedge clk);
        fill_valid = 1'b0;
        beta_wr    = 1'b0;
        clear      = 1'b1;
        out_ready  = 1'b1;
        @(negedge clk);
        clear      = 1'b0;
        fill_valid = 1'b1;
        fill_qty   = 32'h0;
        fill_side  = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        chk("wrap_ffff", 100, {16'd0, fill_count}, 32'h0000_FFFF);
        @(posedge clk);
        #1;
        chk("wrap_zero", 101, {16'd0, fill_count}, 32'h0000_0000);
        chk("wrap_valid", 101, {31'd0, out_valid}, 32'd1);
        fill_valid = 1'b0;
        out_ready  = 1'b0;
        @(posedge clk);
        #1;
        chk("pend_valid", 102, {31'd0, out_valid}, 32'd1);

        // Asynchronous reset with a beat pending.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 103, {31'd0, out_valid}, 32'd0);
        chk("arst_beta",      103, beta_out, 32'h0001_0000);
        chk("arst_count",     103, {16'd0, fill_count}, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b0;
        #1;
        chk("arst_fill_ready", 104, {31'd0, fill_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("arst_no_beat", 105, {31'd0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/position_tracker.md
POSITION_TRACKER -- requirements
Module: position_tracker

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 fill_valid  input  1  fill stream valid.
REQ-004 fill_ready  output  1  fill stream ready.
REQ-005 fill_qty  input  32  unsigned-magnitude fill quantity, Q16.16; bit 31 ignored, treated as 0.
REQ-006 fill_side  input  1  1 = buy (adds to position), 0 = sell (subtracts from position).
REQ-007 beta_wr  input  1  single-cycle strobe that loads beta_cfg.
REQ-008 beta_cfg  input  32  signed beta, Q16.16.
REQ-009 clear  input  1  synchronous position clear request.
REQ-010 out_valid  output  1  position stream valid; feeds the risk stage.
REQ-011 out_ready  input  1  position stream ready.
REQ-012 position_out  output  32  signed net position, Q16.16.
REQ-013 beta_out  output  32  signed beta paired with position_out, Q16.16.
REQ-014 sat_flag  output  1  sticky flag: the position has saturated.
REQ-015 fill_count  output  16  count of accepted fills; wraps modulo 2^16.

Function
REQ-016 A fill is accepted when fill_valid && fill_ready.
REQ-017 fill_ready SHALL equal !clear && (!out_valid || out_ready).
REQ-018 On an accepted fill, the next position SHALL be the current position plus qty (buy) or minus qty (sell). The sum is formed at 33 bits and saturated to the range [0x80000000, 0x7FFFFFFF].
REQ-019 If saturation occurs, sat_flag SHALL set on the same edge and stay set until clear or reset.
REQ-020 Each accepted fill SHALL produce exactly one output beat. On the next edge (latency 1), the beat carries the updated position and the beta in effect for that fill.
REQ-021 If beta_wr and an accepted fill coincide, the new beta_cfg SHALL apply to that fill's beat.
REQ-022 A beta_wr without a fill SHALL update only the internal beta register. It SHALL NOT create a beat and SHALL NOT alter a pending position_out or beta_out.
REQ-023 The output register SHALL hold its value while out_valid && !out_ready.
REQ-024 out_valid SHALL clear when a beat is consumed and no fill is accepted on the same edge.
REQ-025 When a beat is consumed and a fill is accepted on the same edge, out_valid SHALL stay 1 and the output SHALL load the new beat (back-to-back, one fill per cycle).
REQ-026 clear SHALL zero the internal position, sat_flag and fill_count on the next edge.
REQ-027 clear SHALL NOT alter a pending output beat.
REQ-028 clear takes priority over a simultaneous fill: the fill is not accepted and the producer retries.
REQ-029 clear and beta_wr in the same cycle: both take effect.
REQ-030 fill_count SHALL increment by 1 per accepted fill and wrap from 0xFFFF to 0x0000.
REQ-031 fill_qty = 0 SHALL still produce a beat and still increment fill_count.

Reset
REQ-032 While rst_n is low, all of the following SHALL hold:
- position = 0
- position_out = 0
- beta register = 0x00010000 (1.0)
- beta_out = 0x00010000
- out_valid = 0
- sat_flag = 0
- fill_count = 0
REQ-033 Reset mid-operation SHALL discard any pending beat without emitting it.
REQ-034 fill_ready SHALL be 1 in the first cycle after reset deasserts, provided clear = 0.

Structure
REQ-035 The following SHALL be added to fxp_pkg:
- constants Q16_MAX (0x7FFFFFFF), Q16_MIN (0x80000000), Q16_ONE (0x00010000)
- function fxp_sat_add(a, b), returning a Q16.16 value saturated to [Q16_MIN, Q16_MAX]
REQ-036 No sub-module is required. The single-entry output register SHALL be implemented inline.
REQ-037 position_out and beta_out SHALL connect directly to the risk stage's position_in and beta_in.

Verification
REQ-038 Reset, then buy 0x00028000 (2.5), out_ready = 1 -> next cycle: out_valid = 1, position_out = 0x00028000, beta_out = 0x00010000, fill_count = 1.
REQ-039 Sequence buy 3.0, sell 5.0 with out_ready = 1 -> beats are 0x00030000 then 0xFFFE0000 (-2.0); fill_ready stays 1 throughout.
REQ-040 Hold out_ready = 0 with a beat pending, then offer a fill -> fill_ready = 0, position_out unchanged; raise out_ready -> the fill is accepted that cycle and the next beat appears one cycle later.
REQ-041 Position 0x7FFF0000, then buy 0x00020000 -> position_out = 0x7FFFFFFF, sat_flag = 1; a following sell of 1.0 -> 0x7FFEFFFF, sat_flag stays 1.
REQ-042 beta_wr with 0x00008000 in the same cycle as a buy of 1.0 -> beat: beta_out = 0x00008000; next, clear together with a fill -> fill not accepted, position 0, sat_flag 0, fill_count 0, pending beat intact.
REQ-043 Accept 65536 fills of qty 0 -> fill_count wraps to 0x0000; assert rst_n low with a beat pending -> out_valid = 0 immediately.
